router_src_framer: RTL

- Upstream packet source for the 1x3 router.
- Accepts a packet request (destination address and payload length), then collects the payload bytes into an internal buffer and computes running XOR parity.
- Once the packet is fully buffered, drives it into the router's packet input: header byte, payload bytes, then parity byte. It obeys the router's busy back-pressure and captures the router's parity error result.
- Buffering the whole packet first guarantees pkt_vld never drops mid-packet.

---
 rtl/router_src_framer_if.sv | 49 ++++
 rtl/router_src_framer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/router_src_framer_if.sv
// router_src_framer_if: request, payload, router and status signals.
// ROUTER_SRC_CORRUPT_EN adds the corrupt request qualifier.
interface router_src_framer_if;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       req_rdy;
    logic       req_rej;
    logic [7:0] pl_data;
    logic       pl_vld;
    logic       pl_rdy;
    logic       busy;
    logic       err;
    logic       pkt_vld;
    logic [7:0] pkt_data;
    logic       done;
    logic       pkt_err;
`ifdef ROUTER_SRC_CORRUPT_EN
    logic       corrupt;

    modport master (
        input  start, addr, len, corrupt,
        input  pl_data, pl_vld, busy, err,
        output req_rdy, req_rej, pl_rdy,
        output pkt_vld, pkt_data, done, pkt_err
    );

    modport slave (
        output start, addr, len, corrupt,
        output pl_data, pl_vld, busy, err,
        input  req_rdy, req_rej, pl_rdy,
        input  pkt_vld, pkt_data, done, pkt_err
    );
`else
    modport master (
        input  start, addr, len,
        input  pl_data, pl_vld, busy, err,
        output req_rdy, req_rej, pl_rdy,
        output pkt_vld, pkt_data, done, pkt_err
    );

    modport slave (
        output start, addr, len,
        output pl_data, pl_vld, busy, err,
        input  req_rdy, req_rej, pl_rdy,
        input  pkt_vld, pkt_data, done, pkt_err
    );
`endif
endinterface

// File: rtl/router_src_framer.sv
// router_src_framer: buffers a packet, then sends header/payload/parity.
// ROUTER_SRC_CORRUPT_EN: corrupt request flips parity bit 0.
module router_src_framer #(
    parameter int MAX_LEN = 63,
    parameter int ERR_WIN = 3
) (
    input  logic clk,
    input  logic rst,
    router_src_framer_if.master bus
);

    localparam int CW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
    localparam logic [6:0] MaxLen = 7'(MAX_LEN);
    localparam logic [CW-1:0] CntLast = CW'(ERR_WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PLD,
        S_PAR,
        S_CHK
    } state_t;

    state_t state_q, state_d;

    logic [5:0]    len_q, len_d;
    logic [1:0]    addr_q, addr_d;
    logic [5:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    par_q, par_d;
    logic          crpt_q, crpt_d;

    logic       req_rdy_q, req_rdy_d;
    logic       req_rej_q, req_rej_d;
    logic       pl_rdy_q, pl_rdy_d;
    logic       pkt_vld_q, pkt_vld_d;
    logic [7:0] pkt_data_q, pkt_data_d;
    logic       done_q, done_d;
    logic       pkt_err_q, pkt_err_d;

    logic       wr_en;
    logic [7:0] mem_q [MAX_LEN];

    logic       bad_req;
    logic [5:0] last_idx;
    logic [5:0] nxt_idx;

    assign bad_req  = (bus.addr == 2'd3) || (bus.len == 6'd0) ||
                      ({1'b0, bus.len} > MaxLen);
    assign last_idx = len_q - 6'd1;
    assign nxt_idx  = idx_q + 6'd1;

    // Next state, datapath and registered-output values
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        crpt_d     = crpt_q;
        req_rdy_d  = req_rdy_q;
        req_rej_d  = 1'b0;
        pl_rdy_d   = pl_rdy_q;
        pkt_vld_d  = pkt_vld_q;
        pkt_data_d = pkt_data_q;
        done_d     = 1'b0;
        pkt_err_d  = pkt_err_q;
        wr_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && req_rdy_q) begin
                    len_d  = bus.len;
                    addr_d = bus.addr;
                    par_d  = {bus.len, bus.addr};
`ifdef ROUTER_SRC_CORRUPT_EN
                    crpt_d = bus.corrupt;
`else
                    crpt_d = 1'b0;
`endif
                    if (bad_req) begin
                        req_rej_d = 1'b1;
                    end else begin
                        state_d   = S_LOAD;
                        req_rdy_d = 1'b0;
                        pl_rdy_d  = 1'b1;
                        idx_d     = 6'd0;
                        pkt_err_d = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                if (bus.pl_vld && pl_rdy_q) begin
                    wr_en = 1'b1;
                    par_d = par_q ^ bus.pl_data;
                    idx_d = nxt_idx;
                    if (idx_q == last_idx) begin
                        state_d    = S_HDR;
                        pl_rdy_d   = 1'b0;
                        pkt_vld_d  = 1'b1;
                        pkt_data_d = {len_q, addr_q};
                        idx_d      = 6'd0;
                    end
                end
            end
            S_HDR: begin
                if (!bus.busy) begin
                    state_d    = S_PLD;
                    idx_d      = 6'd0;
                    pkt_data_d = mem_q[0];
                end
            end
            S_PLD: begin
                if (!bus.busy) begin
                    if (idx_q == last_idx) begin
                        state_d    = S_PAR;
                        pkt_vld_d  = 1'b0;
                        pkt_data_d = par_q ^ {7'd0, crpt_q};
                    end else begin
                        idx_d      = nxt_idx;
                        pkt_data_d = mem_q[nxt_idx];
                    end
                end
            end
            S_PAR: begin
                if (!bus.busy) begin
                    state_d    = S_CHK;
                    pkt_data_d = 8'd0;
                    cnt_d      = '0;
                end
            end
            S_CHK: begin
                if (bus.err) begin
                    pkt_err_d = 1'b1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    req_rdy_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= 6'd0;
            addr_q     <= 2'd0;
            idx_q      <= 6'd0;
            cnt_q      <= '0;
            par_q      <= 8'd0;
            crpt_q     <= 1'b0;
            req_rdy_q  <= 1'b1;
            req_rej_q  <= 1'b0;
            pl_rdy_q   <= 1'b0;
            pkt_vld_q  <= 1'b0;
            pkt_data_q <= 8'd0;
            done_q     <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            crpt_q     <= crpt_d;
            req_rdy_q  <= req_rdy_d;
            req_rej_q  <= req_rej_d;
            pl_rdy_q   <= pl_rdy_d;
            pkt_vld_q  <= pkt_vld_d;
            pkt_data_q <= pkt_data_d;
            done_q     <= done_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    // Payload buffer; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx_q] <= bus.pl_data;
        end
    end

    assign bus.req_rdy  = req_rdy_q;
    assign bus.req_rej  = req_rej_q;
    assign bus.pl_rdy   = pl_rdy_q;
    assign bus.pkt_vld  = pkt_vld_q;
    assign bus.pkt_data = pkt_data_q;
    assign bus.done     = done_q;
    assign bus.pkt_err  = pkt_err_q;

endmodule
